// File: rtl/audio_mix_pkg.sv
// Shared types and register map for the audio mixer scheduler.
package audio_mix_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DRAIN,
        DONE
    } state_t;

    localparam logic [4:0] GAIN_L_BASE  = 5'd0;
    localparam logic [4:0] GAIN_R_BASE  = 5'd8;
    localparam logic [4:0] MUTE_ADDR    = 5'd16;
    localparam logic [4:0] OVR_CLR_ADDR = 5'd17;

    localparam int unsigned ACC_W      = 19;
    localparam logic [7:0]  GAIN_RESET = 8'h40;

endpackage

// File: rtl/mul8x8_reg.sv
// Registered 8x8 -> 16-bit unsigned multiplier, one clock of latency.
module mul8x8_reg (
    input  logic        clk24,
    input  logic        reset_n,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            p <= '0;
        end else begin
            p <= 16'(a) * 16'(b);
        end
    end

endmodule

// File: rtl/audio_mix_sched.sv
// Eight-source stereo mixer: one shared multiplier walks 16 gain products per frame.
module audio_mix_sched
    import audio_mix_pkg::*;
#(
    parameter int unsigned NSRC      = 8,
    parameter int unsigned OUT_SHIFT = 3
) (
    input  logic                clk24,
    input  logic                reset_n,
    input  logic                sample_ce,
    input  logic [8*NSRC-1:0]   src_data,
    input  logic                cfg_we,
    input  logic [4:0]          cfg_addr,
    input  logic [7:0]          cfg_wdata,
    output logic [15:0]         mix_l,
    output logic [15:0]         mix_r,
    output logic                mix_valid,
    output logic                busy,
    output logic                overrun
);

    state_t state, state_nxt;
    logic [3:0] idx;
    logic       issue, frame_done, in_frame;
    logic       accept, dropped;

    logic [7:0] gain_l [NSRC];
    logic [7:0] gain_r [NSRC];
    logic [7:0] mute;

    logic [7:0] src_act [NSRC];
    logic [7:0] gl_act  [NSRC];
    logic [7:0] gr_act  [NSRC];
    logic [7:0] mute_act;

    logic [7:0]       mul_a, mul_b;
    logic [2:0]       sel;
    logic [15:0]      prod;
    logic             prod_vld, prod_right;
    logic [ACC_W-1:0] acc_l, acc_r;

    assign accept  = sample_ce && (state == IDLE);
    assign dropped = sample_ce && (state != IDLE);

    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= (state == MUL) ? idx + 4'd1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sample_ce) state_nxt = MUL;
            MUL:     if (idx == 4'd15) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue      = (state == MUL);
        frame_done = (state == DONE);
        in_frame   = (state != IDLE);
    end

    // Live configuration registers; only the frame snapshot feeds the datapath.
    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                gain_l[i] <= GAIN_RESET;
                gain_r[i] <= GAIN_RESET;
            end
            mute <= '0;
        end else if (cfg_we) begin
            if (cfg_addr[4:3] == GAIN_L_BASE[4:3]) begin
                gain_l[cfg_addr[2:0]] <= cfg_wdata;
            end else if (cfg_addr[4:3] == GAIN_R_BASE[4:3]) begin
                gain_r[cfg_addr[2:0]] <= cfg_wdata;
            end else if (cfg_addr == MUTE_ADDR) begin
                mute <= cfg_wdata;
            end
        end
    end

    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (dropped) begin
            overrun <= 1'b1;
        end else if (cfg_we && (cfg_addr == OVR_CLR_ADDR)) begin
            overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                src_act[i] <= '0;
                gl_act[i]  <= '0;
                gr_act[i]  <= '0;
            end
            mute_act <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                src_act[i] <= src_data[8*i +: 8];
                gl_act[i]  <= gain_l[i];
                gr_act[i]  <= gain_r[i];
            end
            mute_act <= mute;
        end
    end

    // idx[3] picks the channel; idx[2:0] picks the source within it.
    assign sel = idx[2:0];

    always_comb begin
        mul_a = mute_act[sel] ? '0 : src_act[sel];
        mul_b = idx[3] ? gr_act[sel] : gl_act[sel];
    end

    mul8x8_reg u_mul (
        .clk24   (clk24),
        .reset_n (reset_n),
        .a       (mul_a),
        .b       (mul_b),
        .p       (prod)
    );

    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            prod_vld   <= 1'b0;
            prod_right <= 1'b0;
        end else begin
            prod_vld   <= issue;
            prod_right <= idx[3];
        end
    end

    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            acc_l <= '0;
            acc_r <= '0;
        end else if (accept) begin
            acc_l <= '0;
            acc_r <= '0;
        end else if (prod_vld) begin
            if (prod_right) begin
                acc_r <= acc_r + {{(ACC_W-16){1'b0}}, prod};
            end else begin
                acc_l <= acc_l + {{(ACC_W-16){1'b0}}, prod};
            end
        end
    end

    always_ff @(posedge clk24) begin
        if (!reset_n) begin
            mix_l     <= '0;
            mix_r     <= '0;
            mix_valid <= 1'b0;
        end else begin
            mix_valid <= frame_done;
            if (frame_done) begin
                mix_l <= 16'(acc_l >> OUT_SHIFT);
                mix_r <= 16'(acc_r >> OUT_SHIFT);
            end
        end
    end

    assign busy = in_frame | mix_valid;

endmodule

// File: doc/audio_mix_sched.md
AUDIO_MIX_SCHED -- requirements
Module: audio_mix_sched

Interface
REQ-001 Parameter NSRC, default 8, number of unsigned 8-bit sources; this spec's arithmetic is fixed for 8.
REQ-002 Parameter OUT_SHIFT, default 3, right shift applied to the 19-bit accumulator to form 16-bit outputs.
REQ-003 clk24  in  1  24 MHz system clock; all logic is on its rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low; clock clk24.
REQ-005 sample_ce  in  1  one-clock 48 kHz frame strobe.
REQ-006 src_data  in  64  eight unsigned 8-bit sources; source i is at [8i+7:8i].
REQ-007 cfg_we  in  1  configuration write strobe.
REQ-008 cfg_addr  in  5  register address: 0-7 left gain of src 0-7; 8-15 right gain; 16 mute mask; 17 overrun clear; 18-31 ignored.
REQ-009 cfg_wdata  in  8  write data.
REQ-010 mix_l, mix_r  out  16  unsigned mixed left/right samples, held between frames.
REQ-011 mix_valid  out  1  one-clock pulse when mix_l/mix_r update.
REQ-012 busy  out  1  high while a frame is in progress.
REQ-013 overrun  out  1  sticky flag: sample_ce was dropped.

Function
REQ-014 The block shall use one shared registered 8x8 unsigned multiplier for all 16 gain products, one issue per clock.
REQ-015 FSM states are IDLE, MUL, DRAIN and DONE. IDLE goes to MUL on sample_ce. MUL runs 16 clocks, idx 0..15. MUL goes to DRAIN, DRAIN goes to DONE, and DONE goes to IDLE.
REQ-016 On sample_ce in IDLE, the block shall snapshot src_data, all 16 gains and the mute mask into active copies; both accumulators clear on the same edge.
REQ-017 In MUL: idx 0-7 issues src[idx] x gainL[idx] into acc_l; idx 8-15 issues src[idx-8] x gainR[idx-8] into acc_r. A muted source (mask bit i = 1) contributes 0 to both channels.
REQ-018 Accumulators are 19 bits unsigned. The worst case is 8 x 255 x 255 = 520200, so no overflow or saturation is possible.
REQ-019 In DONE: mix_l = acc_l >> OUT_SHIFT and mix_r = acc_r >> OUT_SHIFT. mix_valid shall be high for exactly one clock, 19 clocks after the sample_ce clock.
REQ-020 busy shall be high from the clock after accepted sample_ce through the mix_valid clock inclusive.
REQ-021 sample_ce outside IDLE shall be ignored: the frame is not restarted and overrun is set to 1.
REQ-022 A cfg write to addr 17 shall clear overrun; if a dropped sample_ce occurs in the same clock, set wins.
REQ-023 Cfg writes take effect immediately in the live registers but only affect the next frame. A write in the same clock as accepted sample_ce is not captured in that frame's snapshot.
REQ-024 Writes to addresses 18-31 shall have no effect.

Reset
REQ-025 On reset_n = 0: FSM goes to IDLE; mix_l, mix_r = 0; mix_valid, busy, overrun = 0; all gains = 8'h40; mute mask = 8'h00; accumulators = 0.
REQ-026 Reset mid-frame shall abort the frame with no mix_valid pulse; the first sample_ce after reset release starts a new frame.

Structure
REQ-027 Shared package audio_mix_pkg shall hold the FSM state enum, register address constants (GAIN_L_BASE = 0, GAIN_R_BASE = 8, MUTE_ADDR = 16, OVR_CLR_ADDR = 17), ACC_W = 19 and GAIN_RESET = 8'h40.
REQ-028 One sub-module, mul8x8_reg (registered 8x8 to 16-bit unsigned multiplier, 1-clock latency), shall be instantiated exactly once.

Verification
REQ-029 Reset; all src = 8'hFF; default gains; one sample_ce -> mix_l = mix_r = 16'd16320, with mix_valid 19 clocks after sample_ce.
REQ-030 gainL[0] = 8'hFF, all other gains 0, src0 = 8'hFF -> mix_l = 16'd8128, mix_r = 0.
REQ-031 All gains 8'hFF, all src 8'hFF -> mix_l = mix_r = 16'd65025, with no wrap.
REQ-032 Second sample_ce 5 clocks after the first -> single mix_valid, overrun = 1; write addr 17 -> overrun = 0.
REQ-033 Write gainL[0] = 0 during MUL -> current frame uses the old gain, next frame uses 0; mute mask 8'h01 zeroes src0 in both channels.
REQ-034 Assert reset_n = 0 at clock 10 of a frame -> no mix_valid; outputs 0, busy 0; next frame completes normally.
